// File: rtl/aerin_tx_if.sv
// Push port and AER bus of the address-event transmitter.
// master = transmitter side, slave = event source plus the AER receiver.
interface aerin_tx_if #(
    parameter int ADDR_W = 17
) ();
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic              in_ready;
    logic [ADDR_W-1:0] AERIN_ADDR;
    logic              AERIN_REQ;
    logic              AERIN_ACK;

    modport master (
        input  in_valid, in_addr, AERIN_ACK,
        output in_ready, AERIN_ADDR, AERIN_REQ
    );

    modport slave (
        output in_valid, in_addr, AERIN_ACK,
        input  in_ready, AERIN_ADDR, AERIN_REQ
    );
endinterface

// File: rtl/aerin_tx.sv
// Buffered AER transmitter: FIFO of events serialised onto a four-phase
// REQ/ACK bus with ACK synchroniser, inter-event gap and handshake timeout.
module aerin_tx #(
    parameter int ADDR_W      = 17,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    aerin_tx_if.master             bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   clr_err,
    output logic [15:0]            sent_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ_HI, S_REQ_LO, S_GAP} state_t;
    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wp, r_rp;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic [TW-1:0]     r_to_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic [15:0]       r_sent;
    logic              r_err;

    logic w_empty, w_full, w_push, w_ack_s, w_to_hit, w_gap_done, w_start;
    logic w_pop, w_req_set, w_req_clr, w_cnt_clr, w_cnt_inc, w_sent_inc, w_err_set, w_gap_clr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = bus.in_valid && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= bus.in_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_raw
            assign w_ack_s = bus.AERIN_ACK;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= (r_sync << 1) | SYNC_STAGES'(bus.AERIN_ACK);
            end
            assign w_ack_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_to_hit   = (TIMEOUT != 0) && (r_to_cnt == TO_LAST);
    assign w_gap_done = (GAP_CYCLES == 0) || (r_gap_cnt == GAP_LAST);
    assign w_start    = !w_empty && !w_ack_s;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_req_set  = 1'b0;
        w_req_clr  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_sent_inc = 1'b0;
        w_err_set  = 1'b0;
        w_gap_clr  = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) begin
                w_next = S_SETUP;
                w_pop  = 1'b1;
            end
            S_SETUP: begin
                w_next    = S_REQ_HI;
                w_req_set = 1'b1;
                w_cnt_clr = 1'b1;
            end
            S_REQ_HI: begin
                if (w_ack_s) begin
                    w_next    = S_REQ_LO;
                    w_req_clr = 1'b1;
                    w_cnt_clr = 1'b1;
                end else if (w_to_hit) begin
                    w_next    = S_GAP;
                    w_req_clr = 1'b1;
                    w_err_set = 1'b1;
                    w_gap_clr = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_REQ_LO: begin
                if (!w_ack_s) begin
                    w_next     = S_GAP;
                    w_sent_inc = 1'b1;
                    w_gap_clr  = 1'b1;
                end else if (w_to_hit) begin
                    w_next    = S_GAP;
                    w_err_set = 1'b1;
                    w_gap_clr = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_GAP: begin
                // A receiver still holding ACK keeps us here regardless of the gap count.
                if (!w_ack_s && w_gap_done) begin
                    if (w_start) begin
                        w_next = S_SETUP;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_req     <= 1'b0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_sent    <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_pop) r_addr <= r_mem[r_rp[AW-1:0]];
            if (w_req_set)      r_req <= 1'b1;
            else if (w_req_clr) r_req <= 1'b0;
            if (w_cnt_clr)      r_to_cnt <= '0;
            else if (w_cnt_inc) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_gap_clr)                          r_gap_cnt <= '0;
            else if (r_state == S_GAP && !w_gap_done) r_gap_cnt <= r_gap_cnt + 1'b1;
            if (w_sent_inc) r_sent <= r_sent + 16'd1;
            if (w_err_set)    r_err <= 1'b1;
            else if (clr_err) r_err <= 1'b0;
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.AERIN_ADDR = r_addr;
    assign bus.AERIN_REQ  = r_req;
    assign fifo_count     = r_wp - r_rp;
    assign busy           = (r_state != S_IDLE) || !w_empty;
    assign timeout_err    = r_err;
    assign sent_count     = r_sent;
endmodule

// File: tb/tb_aerin_tx.sv
// Directed bench for aerin_tx: dA has the timeout disabled, dB uses TIMEOUT=8.
// Each ACK responder either echoes REQ one cycle late or holds a constant level.
module tb_aerin_tx;
    localparam int AW = 17;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aerin_tx_if #(.ADDR_W(AW)) ba ();
    aerin_tx_if #(.ADDR_W(AW)) bb ();

    logic [CW-1:0] cnt_a, cnt_b;
    logic          busy_a, busy_b, err_a, err_b, clr_a, clr_b;
    logic [15:0]   sent_a, sent_b;

    aerin_tx #(.TIMEOUT(0)) dA (
        .clk(clk), .rst(rst), .bus(ba), .fifo_count(cnt_a), .busy(busy_a),
        .timeout_err(err_a), .clr_err(clr_a), .sent_count(sent_a)
    );
    aerin_tx #(.TIMEOUT(8)) dB (
        .clk(clk), .rst(rst), .bus(bb), .fifo_count(cnt_b), .busy(busy_b),
        .timeout_err(err_b), .clr_err(clr_b), .sent_count(sent_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mode_a = 0, mode_b = 0;   // 0: ACK <= REQ, 1: ACK held 0, 2: ACK held 1
    int addr_viol = 0;
    logic [AW-1:0] rise_a[$], rise_b[$], exp_q[$];
    int rise_t_b[$];

    typedef struct {
        logic          vld;
        logic [AW-1:0] din;
        logic          req;
        logic [AW-1:0] addr;
        logic [15:0]   sent;
        logic          busy;
        logic [CW-1:0] cnt;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        logic pra, prb, pka, pkb;
        logic [AW-1:0] paa, pab;
        @(negedge clk);
        pra = ba.AERIN_REQ; prb = bb.AERIN_REQ;
        pka = ba.AERIN_ACK; pkb = bb.AERIN_ACK;
        paa = ba.AERIN_ADDR; pab = bb.AERIN_ADDR;
        @(posedge clk);
        #1;
        cyc++;
        ba.AERIN_ACK = (mode_a == 0) ? pra : (mode_a == 2);
        bb.AERIN_ACK = (mode_b == 0) ? prb : (mode_b == 2);
        if (ba.AERIN_REQ && !pra) rise_a.push_back(ba.AERIN_ADDR);
        if (bb.AERIN_REQ && !prb) begin
            rise_b.push_back(bb.AERIN_ADDR);
            rise_t_b.push_back(cyc);
        end
        if (!rst && ba.AERIN_ADDR !== paa && (pra || pka)) addr_viol++;
        if (!rst && bb.AERIN_ADDR !== pab && (prb || pkb)) addr_viol++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n, hi, acc;
        tbl[0] = '{1'b1, 17'h10001, 1'b0, 17'h00000, 16'd0, 1'b1, 5'd1};
        tbl[1] = '{1'b0, 17'h00000, 1'b0, 17'h10001, 16'd0, 1'b1, 5'd0};
        for (int k = 2; k <= 5; k++) tbl[k] = '{1'b0, 17'h0, 1'b1, 17'h10001, 16'd0, 1'b1, 5'd0};
        for (int k = 6; k <= 9; k++) tbl[k] = '{1'b0, 17'h0, 1'b0, 17'h10001, 16'd0, 1'b1, 5'd0};
        tbl[10] = '{1'b0, 17'h0, 1'b0, 17'h10001, 16'd1, 1'b1, 5'd0};
        tbl[11] = '{1'b0, 17'h0, 1'b0, 17'h10001, 16'd1, 1'b1, 5'd0};
        tbl[12] = '{1'b0, 17'h0, 1'b0, 17'h10001, 16'd1, 1'b0, 5'd0};

        rst = 1'b1;
        ba.in_valid = 1'b0; ba.in_addr = '0; ba.AERIN_ACK = 1'b0;
        bb.in_valid = 1'b0; bb.in_addr = '0; bb.AERIN_ACK = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) step();
        chk("rst_req", {bb.AERIN_REQ, ba.AERIN_REQ}, 0);
        chk("rst_addr_a", ba.AERIN_ADDR, 0);
        chk("rst_addr_b", bb.AERIN_ADDR, 0);
        chk("rst_ready", {bb.in_ready, ba.in_ready}, 2'b11);
        chk("rst_count", {cnt_b, cnt_a}, 0);
        chk("rst_busy", {busy_b, busy_a}, 0);
        chk("rst_err", {err_b, err_a}, 0);
        chk("rst_sent", {sent_b, sent_a}, 0);
        rst = 1'b0;

        // Single event, cycle-by-cycle against the table
        for (int k = 0; k < 13; k++) begin
            bb.in_valid = tbl[k].vld;
            bb.in_addr  = tbl[k].din;
            step();
            chk($sformatf("single_req_E%0d", k), bb.AERIN_REQ, tbl[k].req);
            chk($sformatf("single_addr_E%0d", k), bb.AERIN_ADDR, tbl[k].addr);
            chk($sformatf("single_sent_E%0d", k), sent_b, tbl[k].sent);
            chk($sformatf("single_busy_E%0d", k), busy_b, tbl[k].busy);
            chk($sformatf("single_cnt_E%0d", k), cnt_b, tbl[k].cnt);
        end

        // Back-to-back: four pushes on consecutive edges
        do_reset();
        rise_b.delete(); rise_t_b.delete(); exp_q.delete();
        exp_q.push_back(17'h10001); exp_q.push_back(17'h10002);
        exp_q.push_back(17'h10004); exp_q.push_back(17'h000FF);
        for (int i = 0; i < 4; i++) begin
            bb.in_valid = 1'b1; bb.in_addr = exp_q[i];
            step();
        end
        bb.in_valid = 1'b0;
        n = 0;
        while (busy_b && n < 100) begin step(); n++; end
        chk("b2b_drain_bound", n < 100, 1);
        chk("b2b_nreq", rise_b.size(), 4);
        if (rise_b.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("b2b_addr%0d", i), rise_b[i], exp_q[i]);
                if (i > 0) chk($sformatf("b2b_space%0d", i), rise_t_b[i] - rise_t_b[i-1], 11);
            end
        chk("b2b_sent", sent_b, 4);

        // Full FIFO on dA: ACK held low, timeout disabled
        do_reset();
        mode_a = 1; rise_a.delete(); exp_q.delete(); acc = 0;
        for (int i = 0; i < 18; i++) begin
            ba.in_valid = 1'b1;
            ba.in_addr  = 17'h00100 + 17'(i);
            if (!ba.in_ready) break;
            exp_q.push_back(ba.in_addr);
            step();
            acc++;
        end
        repeat (3) step();
        chk("full_accepted", acc, 17);
        chk("full_count", cnt_a, 16);
        chk("full_ready", ba.in_ready, 0);
        ba.in_valid = 1'b0;
        mode_a = 0;
        n = 0;
        while (sent_a != 16'd17 && n < 400) begin step(); n++; end
        chk("full_drain_bound", n < 400, 1);
        chk("full_nreq", rise_a.size(), 17);
        if (rise_a.size() == 17)
            for (int i = 0; i < 17; i++) chk($sformatf("full_order%0d", i), rise_a[i], exp_q[i]);
        chk("full_err", err_a, 0);

        // Timeout on dB: ACK held low, two events queued
        do_reset();
        mode_b = 1;
        bb.in_valid = 1'b1; bb.in_addr = 17'h1AAAA; step();
        bb.in_addr = 17'h0BBBB; step();
        bb.in_valid = 1'b0;
        hi = 0;
        for (int k = 2; k <= 10; k++) begin step(); if (bb.AERIN_REQ) hi++; end
        chk("to_req_hi_cycles", hi, 9);
        chk("to_err_before", err_b, 0);
        step();                             // E11: timeout fires
        chk("to_req_drop", bb.AERIN_REQ, 0);
        chk("to_err_set", err_b, 1);
        chk("to_sent", sent_b, 0);
        step();                             // E12
        chk("to_gap_req", bb.AERIN_REQ, 0);
        step();                             // E13: SETUP of second event
        chk("to_next_addr", bb.AERIN_ADDR, 17'h0BBBB);
        step();                             // E14
        chk("to_next_req", bb.AERIN_REQ, 1);
        repeat (8) step();                  // through E22
        clr_b = 1'b1;
        step();                             // E23: timeout and clear together
        chk("to_set_wins", err_b, 1);
        step();                             // E24
        clr_b = 1'b0;
        chk("to_clr", err_b, 0);
        chk("to_sent_final", sent_b, 0);
        repeat (2) step();
        chk("to_idle", busy_b, 0);

        // Stuck ACK on dA: ACK rises again right after the handshake
        do_reset();
        mode_a = 0; rise_a.delete();
        ba.in_valid = 1'b1; ba.in_addr = 17'h10ABC; step();
        ba.in_addr = 17'h00055; step();
        ba.in_valid = 1'b0;
        repeat (6) step();                  // through E7
        mode_a = 2;
        repeat (3) step();                  // E8..E10
        chk("stuck_sent1", sent_a, 1);
        hi = 0;
        for (int k = 0; k < 20; k++) begin step(); if (ba.AERIN_REQ) hi++; end
        chk("stuck_no_req", hi, 0);
        chk("stuck_busy", busy_a, 1);
        chk("stuck_count", cnt_a, 1);
        mode_a = 0;
        n = 0;
        while (sent_a != 16'd2 && n < 60) begin step(); n++; end
        chk("stuck_resume_bound", n < 60, 1);
        chk("stuck_nreq", rise_a.size(), 2);
        if (rise_a.size() == 2) chk("stuck_addr2", rise_a[1], 17'h00055);

        // Reset mid-handshake on dA, sent_count still 2 from above
        mode_a = 1;
        for (int i = 0; i < 4; i++) begin
            ba.in_valid = 1'b1; ba.in_addr = 17'h12340 + 17'(i);
            step();
        end
        ba.in_valid = 1'b0;
        chk("mid_req_pre", ba.AERIN_REQ, 1);
        chk("mid_cnt_pre", cnt_a, 3);
        rst = 1'b1;
        step();
        chk("mid_req", ba.AERIN_REQ, 0);
        chk("mid_addr", ba.AERIN_ADDR, 0);
        chk("mid_cnt", cnt_a, 0);
        chk("mid_sent", sent_a, 0);
        rst = 1'b0;
        mode_a = 0;
        hi = 0;
        for (int k = 0; k < 10; k++) begin step(); if (ba.AERIN_REQ || busy_a) hi++; end
        chk("mid_quiet", hi, 0);
        ba.in_valid = 1'b1; ba.in_addr = 17'h00777; step();
        ba.in_valid = 1'b0;
        step();
        chk("mid_new_addr", ba.AERIN_ADDR, 17'h00777);
        step();
        chk("mid_new_req", ba.AERIN_REQ, 1);

        chk("addr_hold", addr_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
